mod_counter: RTL and testbench

Parametrised wrap-around counter for the clock's time and date fields: seconds, minutes, hours, days, months and years. It counts on an external tick rather than every clock. It accepts manual inc/dec edits while set mode is active, and it supports a direct load. The upper bound is a runtime input, so one day counter can follow a month length of 28..31, and it clamps the count when that bound shrinks. Instances cascade through `wrap_next` (zero-latency) or `carry_out` (registered).

---
 rtl/mod_counter.sv | 85 ++++++++
 tb/tb_mod_counter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mod_counter.sv
// Wrap-around field counter (sec/min/hour/day/month/year) advanced by tick or set-mode edits.
// One-cycle latency to count/carry_out; wrap_next is same-cycle; no backpressure, one action per edge.
module mod_counter #(
  parameter int WIDTH     = 6,
  parameter int MIN_VAL   = 0,
  parameter int RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             ctrl_set,
  input  logic             inc,
  input  logic             dec,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] max_val,
  output logic [WIDTH-1:0] count,
  output logic             carry_out,
  output logic             wrap_next,
  output logic             at_max
);

  localparam logic [WIDTH:0] MIN_EXT = MIN_VAL[WIDTH:0];
  localparam logic [WIDTH:0] ONE     = {{WIDTH{1'b0}}, 1'b1};

  logic [WIDTH:0] count_ext;
  logic [WIDTH:0] max_ext;
  logic [WIDTH:0] lv_ext;
  logic [WIDTH:0] eff_max;
  logic [WIDTH:0] incr_ext;
  logic [WIDTH:0] decr_ext;
  logic [WIDTH:0] next_ext;
  logic           next_carry;
  logic           unused_next_msb;

  // Widened by one bit so count+1 never overflows at the top of the range.
  assign count_ext = {1'b0, count};
  assign max_ext   = {1'b0, max_val};
  assign lv_ext    = {1'b0, load_val};
  assign eff_max   = (max_ext < MIN_EXT) ? MIN_EXT : max_ext;

  assign at_max    = (count_ext == eff_max);
  assign wrap_next = tick & ~ctrl_set & ~load & at_max;

  assign incr_ext  = at_max ? MIN_EXT : (count_ext + ONE);
  assign decr_ext  = (count_ext == MIN_EXT) ? eff_max : (count_ext - ONE);

  always_comb begin
    next_ext   = count_ext;
    next_carry = 1'b0;
    if (load) begin
      if (lv_ext < MIN_EXT)
        next_ext = MIN_EXT;
      else if (lv_ext > eff_max)
        next_ext = eff_max;
      else
        next_ext = lv_ext;
    end else if (count_ext > eff_max) begin
      // Bound shrank underneath us (e.g. month length 31 -> 28).
      next_ext = eff_max;
    end else if (ctrl_set) begin
      if (inc && !dec)
        next_ext = incr_ext;
      else if (dec && !inc)
        next_ext = decr_ext;
    end else if (tick) begin
      next_ext   = incr_ext;
      next_carry = at_max;
    end
  end

  // Every next_ext choice is bounded by eff_max, so its top bit is always zero.
  assign unused_next_msb = next_ext[WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= RESET_VAL[WIDTH-1:0];
      carry_out <= 1'b0;
    end else begin
      count     <= next_ext[WIDTH-1:0];
      carry_out <= next_carry;
    end
  end

endmodule

// File: tb/tb_mod_counter.sv
// Directed checks of mod_counter: seconds/minutes cascade plus a day field (MIN_VAL=1).
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       sec_tick = 0, sec_set = 0, sec_inc = 0, sec_dec = 0, sec_load = 0;
  logic [5:0] sec_lv = '0, sec_max = 6'd59;
  logic [5:0] sec_count;
  logic       sec_carry, sec_wrap, sec_at_max;

  logic       min_load = 0;
  logic [5:0] min_lv = '0, min_max = 6'd59;
  logic [5:0] min_count;
  logic       min_carry, min_wrap, min_at_max;

  logic       day_tick = 0, day_set = 0, day_inc = 0, day_dec = 0, day_load = 0;
  logic [5:0] day_lv = '0, day_max = 6'd31;
  logic [5:0] day_count;
  logic       day_carry, day_wrap, day_at_max;

  int checks = 0;
  int errors = 0;

  mod_counter #(.WIDTH(6), .MIN_VAL(0), .RESET_VAL(0)) u_sec (
    .clk(clk), .rst(rst), .tick(sec_tick), .ctrl_set(sec_set), .inc(sec_inc), .dec(sec_dec),
    .load(sec_load), .load_val(sec_lv), .max_val(sec_max), .count(sec_count),
    .carry_out(sec_carry), .wrap_next(sec_wrap), .at_max(sec_at_max)
  );

  mod_counter #(.WIDTH(6), .MIN_VAL(0), .RESET_VAL(0)) u_min (
    .clk(clk), .rst(rst), .tick(sec_wrap), .ctrl_set(1'b0), .inc(1'b0), .dec(1'b0),
    .load(min_load), .load_val(min_lv), .max_val(min_max), .count(min_count),
    .carry_out(min_carry), .wrap_next(min_wrap), .at_max(min_at_max)
  );

  mod_counter #(.WIDTH(6), .MIN_VAL(1), .RESET_VAL(1)) u_day (
    .clk(clk), .rst(rst), .tick(day_tick), .ctrl_set(day_set), .inc(day_inc), .dec(day_dec),
    .load(day_load), .load_val(day_lv), .max_val(day_max), .count(day_count),
    .carry_out(day_carry), .wrap_next(day_wrap), .at_max(day_at_max)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #17;
    check("rst_sec_count", sec_count, 0);
    check("rst_sec_carry", sec_carry, 0);
    check("rst_day_count", day_count, 1);
    check("rst_sec_wrap", sec_wrap, 0);
    @(negedge clk);
    rst = 1'b0;

    // 60 ticks: 0..59 then back to 0 with a single carry pulse.
    sec_tick = 1;
    for (int i = 0; i < 60; i++) begin
      check("tick_wrap_next", sec_wrap, (i == 59) ? 1 : 0);
      step();
      check("tick_count", sec_count, (i + 1) % 60);
      check("tick_carry", sec_carry, (i == 59) ? 1 : 0);
    end
    check("tick_min_count", min_count, 1);
    sec_tick = 0;
    step();
    check("tick_carry_drop", sec_carry, 0);

    // Edit mode on seconds.
    sec_set = 1; sec_dec = 1;
    step();
    check("edit_dec_wrap", sec_count, 59);
    check("edit_dec_carry", sec_carry, 0);
    sec_dec = 0; sec_tick = 1;
    #1 check("edit_tick_wrap_next", sec_wrap, 0);
    step();
    check("edit_tick_ignored", sec_count, 59);
    check("edit_tick_carry", sec_carry, 0);
    check("edit_tick_min_hold", min_count, 1);
    sec_tick = 0; sec_inc = 1;
    step();
    check("edit_inc_wrap", sec_count, 0);
    check("edit_inc_carry", sec_carry, 0);
    sec_dec = 1;
    step();
    check("edit_both_hold", sec_count, 0);
    sec_inc = 0; sec_dec = 0; sec_set = 0;

    // Day field: load, bound shrink, tick wrap.
    day_lv = 31; day_load = 1;
    step();
    check("day_load31", day_count, 31);
    day_load = 0; day_max = 28;
    #1 check("day_shrink_at_max", day_at_max, 0);
    step();
    check("day_clamp28", day_count, 28);
    check("day_clamp_carry", day_carry, 0);
    day_tick = 1;
    #1 check("day_wrap_next", day_wrap, 1);
    step();
    check("day_tick_wrap", day_count, 1);
    check("day_tick_carry", day_carry, 1);
    day_tick = 0;

    // Load clamping.
    day_lv = 0; day_load = 1;
    step();
    check("load_below_min", day_count, 1);
    day_lv = 63; day_max = 23;
    step();
    check("load_above_max", day_count, 23);
    day_lv = 5; day_tick = 1;
    #1 check("load_tick_wrap_next", day_wrap, 0);
    step();
    check("load_beats_tick", day_count, 5);
    check("load_beats_tick_carry", day_carry, 0);
    day_load = 0; day_tick = 0;

    // Degenerate bound: max_val below MIN_VAL.
    day_max = 0;
    step();
    check("degen_clamp", day_count, 1);
    check("degen_clamp_carry", day_carry, 0);
    check("degen_at_max", day_at_max, 1);
    day_tick = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("degen_count", day_count, 1);
      check("degen_carry", day_carry, 1);
    end
    day_tick = 0;

    // Cascade from 59:59, then async reset mid-cycle.
    sec_lv = 59; sec_load = 1; min_lv = 59; min_load = 1;
    day_max = 31; day_lv = 20; day_load = 1;
    step();
    check("casc_pre_sec", sec_count, 59);
    check("casc_pre_min", min_count, 59);
    check("casc_pre_day", day_count, 20);
    sec_load = 0; min_load = 0; day_load = 0; sec_tick = 1;
    #1 check("casc_wrap_next", sec_wrap, 1);
    step();
    check("casc_sec", sec_count, 0);
    check("casc_min", min_count, 0);
    check("casc_sec_carry", sec_carry, 1);
    check("casc_min_carry", min_carry, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_sec", sec_count, 0);
    check("arst_min", min_count, 0);
    check("arst_day", day_count, 1);
    check("arst_sec_carry", sec_carry, 0);
    check("arst_min_carry", min_carry, 0);
    sec_tick = 0;
    @(negedge clk);
    rst = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
